led_mode_ctrl: RTL and testbench
================================

// Module: led_mode_ctrl
// PURPOSE
//  Produces the 3-bit led_mode consumed by the LED driver
//  (0 off, 1 on, 2 blink, 3 breathing).
//  - A debounced push-button cycles the mode; a long press forces LED off.
//  - A host command port (e.g. a UART command decoder) can load a mode directly.
//  - Sits between board key / command logic and the LED driver; one clock, 24 MHz.
// PARAMETERS
//  DEBOUNCE_CYC  240_000     consecutive stable cycles to accept a key edge (10 ms)
//  LONG_CYC      24_000_000  cycles held (after press debounce) that make a long press (1 s)
//  NUM_MODES     4           modes cycled by short press: 0..NUM_MODES-1
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-low
//  key_n          in   1  raw button, active-low, asynchronous to clk, bouncy
//  host_mode_vld  in   1  one-cycle strobe: load host_mode
//  host_mode      in   3  requested mode, sampled when host_mode_vld=1
//  led_mode       out  3  current mode to the LED driver (registered)
//  mode_chg       out  1  one-cycle pulse on any led_mode update (even if value unchanged)
//  key_evt        out  2  one-cycle: 2'b01 short press, 2'b10 long press, else 0
// BEHAVIOUR
//  Reset (rst=0 at posedge): led_mode=0, mode_chg=0, key_evt=0, FSM=IDLE,
//   counter=0, both key sync FFs=1 (released).
//  Input sync: key_n -> 2-FF synchroniser -> key_s; FSM uses key_s only (2-cycle latency).
//  FSM (counter cnt, width clog2(LONG_CYC+1)):
//   IDLE     : key_s=0 -> DEB_DN, cnt=0.
//   DEB_DN   : key_s=1 -> IDLE. Else cnt++; cnt==DEBOUNCE_CYC-1 -> HELD, cnt=0.
//   HELD     : key_s=1 -> DEB_UP (short candidate). Else cnt++; cnt==LONG_CYC-1 ->
//              LONG, fire long action.
//   LONG     : key_s=1 -> DEB_UP (long flag set, no further action).
//   DEB_UP   : key_s=0 -> cnt=0, stay (bounce restarts count). Else cnt++;
//              cnt==DEBOUNCE_CYC-1 -> IDLE, fire short action if not long.
//  Short action: led_mode <= (led_mode>=NUM_MODES-1) ? 0 : led_mode+1;
//   key_evt=01, mode_chg=1, same edge.
//   Wrap: 3 -> 0. A host-loaded value >= NUM_MODES also wraps to 0.
//  Long action: led_mode <= 0, key_evt=10, mode_chg=1.
//   Fires exactly once per press, while still held. The release never fires a short.
//  Host load: host_mode_vld=1 and host_mode<=3 -> led_mode<=host_mode, mode_chg=1
//   on the next edge. host_mode>3 is ignored (no pulse).
//  Simultaneous host load and key action on the same edge: host value wins.
//   key_evt still pulses, but the key's mode effect is discarded.
//   FSM progresses normally.
//  Reset mid-press: everything returns to reset values. A key still held after reset
//   needs a full debounce from IDLE before it counts.
//  Outputs are registered and glitch-free. led_mode holds between events.
// TESTING (bench params DEBOUNCE_CYC=4, LONG_CYC=20)
//  1 Reset, key_n=1 -> led_mode=0, mode_chg=0, key_evt=0 for all cycles.
//  2 key_n low 10 cyc, then high 10 cyc -> one key_evt=01,
//    led_mode 0->1 ~2+4 cyc after release.
//    Repeat 4x -> sequence 1,2,3,0.
//  3 key_n toggles every 2 cyc for 20 cyc, then high -> no key_evt, led_mode unchanged.
//  4 led_mode=2, key_n low 40 cyc -> key_evt=10 and led_mode=0 at ~26 cyc into the press.
//    Release -> no further pulse, led_mode stays 0.
//  5 host_mode_vld with host_mode=3 -> led_mode=3 and mode_chg next edge.
//    host_mode=6 -> ignored.
//    Host strobe on the same edge as a short action -> led_mode = host value.
//  6 rst=0 while in HELD with key still low -> led_mode=0, FSM=IDLE.
//    After rst=1, key held 10 cyc then released -> exactly one short press (led_mode=1).

Source files
------------

// File: rtl/led_mode_ctrl.sv
// LED mode controller: a debounced key cycles the LED mode, a long press forces it off,
// and a host command port can load a mode directly.
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 240_000,
  parameter int LONG_CYC     = 24_000_000,
  parameter int NUM_MODES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       host_mode_vld,
  input  logic [2:0] host_mode,
  output logic [2:0] led_mode,
  output logic       mode_chg,
  output logic [1:0] key_evt
);

  // state  | meaning
  // IDLE   | key released and stable
  // DEB_DN | key low, counting down-debounce
  // HELD   | press accepted, timing toward a long press
  // LONG   | long action fired, waiting for release
  // DEB_UP | key high, counting release debounce

  localparam int CW = $clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] DEB_TC   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_TC  = CW'(LONG_CYC - 1);
  localparam logic [2:0]    MODE_MAX = 3'(NUM_MODES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEB_DN = 3'd1,
    HELD   = 3'd2,
    LONG   = 3'd3,
    DEB_UP = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          long_flag, long_nx;
  logic          key_meta, key_s;
  logic          fire_short, fire_long;
  logic [2:0]    led_nx;
  logic          chg_nx;
  logic [1:0]    evt_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_meta  <= 1'b1;
      key_s     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      long_flag <= 1'b0;
      led_mode  <= 3'd0;
      mode_chg  <= 1'b0;
      key_evt   <= 2'b00;
    end else begin
      key_meta  <= key_n;
      key_s     <= key_meta;
      state     <= state_nx;
      cnt       <= cnt_nx;
      long_flag <= long_nx;
      led_mode  <= led_nx;
      mode_chg  <= chg_nx;
      key_evt   <= evt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    long_nx    = long_flag;
    fire_short = 1'b0;
    fire_long  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_nx = DEB_DN;
          cnt_nx   = '0;
        end
      end
      DEB_DN: begin
        if (key_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_TC) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (key_s) begin
          state_nx = DEB_UP;
          cnt_nx   = '0;
          long_nx  = 1'b0;
        end else if (cnt == LONG_TC) begin
          state_nx  = LONG;
          cnt_nx    = '0;
          fire_long = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      LONG: begin
        if (key_s) begin
          state_nx = DEB_UP;
          cnt_nx   = '0;
          long_nx  = 1'b1;
        end
      end
      DEB_UP: begin
        // A bounce back low restarts the release debounce rather than re-arming a press.
        if (!key_s) begin
          cnt_nx = '0;
        end else if (cnt == DEB_TC) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          fire_short = !long_flag;
          long_nx    = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        long_nx  = 1'b0;
      end
    endcase
  end

  always_comb begin
    led_nx = led_mode;
    chg_nx = 1'b0;
    evt_nx = 2'b00;
    if (fire_short) begin
      evt_nx = 2'b01;
      chg_nx = 1'b1;
      led_nx = (led_mode >= MODE_MAX) ? 3'd0 : led_mode + 3'd1;
    end
    if (fire_long) begin
      evt_nx = 2'b10;
      chg_nx = 1'b1;
      led_nx = 3'd0;
    end
    // Host command overrides the key's mode effect on a coincident edge.
    if (host_mode_vld && (host_mode <= 3'd3)) begin
      chg_nx = 1'b1;
      led_nx = host_mode;
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: table of key/host vectors plus hand-written
// sequences for bounce, coincident host/key, and reset during a press.
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       host_mode_vld;
  logic [2:0] host_mode;
  logic [2:0] led_mode;
  logic       mode_chg;
  logic [1:0] key_evt;

  int n_chk = 0;
  int n_bad = 0;
  int ns, nl, nc;

  always #5 clk = ~clk;

  led_mode_ctrl #(.DEBOUNCE_CYC(4), .LONG_CYC(20), .NUM_MODES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .host_mode_vld (host_mode_vld),
    .host_mode     (host_mode),
    .led_mode      (led_mode),
    .mode_chg      (mode_chg),
    .key_evt       (key_evt)
  );

  typedef struct {
    int         low;
    int         high;
    bit         hv;
    logic [2:0] hm;
    logic [2:0] exp_led;
    int         exp_s;
    int         exp_l;
    int         exp_c;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(int low, int high, bit hv, logic [2:0] hm,
                              logic [2:0] el, int es, int el2, int ec);
    vec_t v;
    v.low = low; v.high = high; v.hv = hv; v.hm = hm;
    v.exp_led = el; v.exp_s = es; v.exp_l = el2; v.exp_c = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for the next posedge, then sample at the following negedge.
  task automatic cyc(input logic kn, input logic hv, input logic [2:0] hm);
    key_n = kn;
    host_mode_vld = hv;
    host_mode = hm;
    @(negedge clk);
    if (key_evt == 2'b01) ns++;
    if (key_evt == 2'b10) nl++;
    if (mode_chg) nc++;
  endtask

  task automatic clr();
    ns = 0; nl = 0; nc = 0;
  endtask

  initial begin
    rst = 1'b0;
    key_n = 1'b1;
    host_mode_vld = 1'b0;
    host_mode = 3'd0;
    clr();

    vecs[0]  = mk(10, 10, 0, 3'd0, 3'd1, 1, 0, 1);
    vecs[1]  = mk(10, 10, 0, 3'd0, 3'd2, 1, 0, 1);
    vecs[2]  = mk(10, 10, 0, 3'd0, 3'd3, 1, 0, 1);
    vecs[3]  = mk(10, 10, 0, 3'd0, 3'd0, 1, 0, 1);
    vecs[4]  = mk(0,  3,  1, 3'd3, 3'd3, 0, 0, 1);
    vecs[5]  = mk(0,  3,  1, 3'd6, 3'd3, 0, 0, 0);
    vecs[6]  = mk(10, 10, 0, 3'd0, 3'd0, 1, 0, 1);
    vecs[7]  = mk(0,  3,  1, 3'd2, 3'd2, 0, 0, 1);
    vecs[8]  = mk(0,  3,  1, 3'd2, 3'd2, 0, 0, 1);
    vecs[9]  = mk(40, 12, 0, 3'd0, 3'd0, 0, 1, 1);
    vecs[10] = mk(0,  3,  1, 3'd7, 3'd0, 0, 0, 0);
    vecs[11] = mk(0,  3,  1, 3'd1, 3'd1, 0, 0, 1);
    vecs[12] = mk(10, 10, 0, 3'd0, 3'd2, 1, 0, 1);

    // Reset holds all outputs at zero, and they stay there while idle afterwards.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 3'd0);
      chk("reset_outputs", int'({led_mode, mode_chg, key_evt}), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 3'd0);
      chk("idle_outputs", int'({led_mode, mode_chg, key_evt}), 0);
    end

    foreach (vecs[k]) begin
      clr();
      for (int c = 1; c <= vecs[k].low + vecs[k].high; c++)
        cyc((c <= vecs[k].low) ? 1'b0 : 1'b1, (c == 1) && vecs[k].hv, vecs[k].hm);
      chk($sformatf("vec%0d_led", k), int'(led_mode), int'(vecs[k].exp_led));
      chk($sformatf("vec%0d_short", k), ns, vecs[k].exp_s);
      chk($sformatf("vec%0d_long", k), nl, vecs[k].exp_l);
      chk($sformatf("vec%0d_chg", k), nc, vecs[k].exp_c);
    end

    // Bouncing key never survives debounce.
    clr();
    for (int c = 1; c <= 20; c++) cyc((((c - 1) / 2) % 2) ? 1'b1 : 1'b0, 1'b0, 3'd0);
    for (int c = 1; c <= 10; c++) cyc(1'b1, 1'b0, 3'd0);
    chk("bounce_led", int'(led_mode), 2);
    chk("bounce_evt", ns + nl, 0);
    chk("bounce_chg", nc, 0);

    // Host strobe on the exact edge of the short action: host value wins.
    cyc(1'b1, 1'b1, 3'd0);
    cyc(1'b1, 1'b0, 3'd0);
    chk("pre_coinc_led", int'(led_mode), 0);
    clr();
    for (int c = 1; c <= 20; c++) begin
      cyc((c <= 10) ? 1'b0 : 1'b1, c == 17, 3'd2);
      if (c == 17) begin
        chk("coinc_evt", int'(key_evt), 1);
        chk("coinc_led", int'(led_mode), 2);
        chk("coinc_chg", int'(mode_chg), 1);
      end
    end
    chk("coinc_short_cnt", ns, 1);
    chk("coinc_chg_cnt", nc, 1);
    chk("coinc_led_hold", int'(led_mode), 2);

    // Reset while the press is in HELD, key still low; then a fresh full press.
    cyc(1'b1, 1'b1, 3'd3);
    cyc(1'b1, 1'b0, 3'd0);
    chk("pre_rst_led", int'(led_mode), 3);
    for (int c = 1; c <= 12; c++) cyc(1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      cyc(1'b0, 1'b0, 3'd0);
      chk("midpress_rst_outputs", int'({led_mode, mode_chg, key_evt}), 0);
    end
    rst = 1'b1;
    clr();
    for (int c = 1; c <= 10; c++) cyc(1'b0, 1'b0, 3'd0);
    for (int c = 1; c <= 10; c++) cyc(1'b1, 1'b0, 3'd0);
    chk("post_rst_short", ns, 1);
    chk("post_rst_long", nl, 0);
    chk("post_rst_led", int'(led_mode), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
